// File: rtl/sd_op_seq.sv
// Program-driven Wishbone master sequencing SD-controller register ops; FETCH 1 cycle, bus op 1+(ack latency+1) cycles.
// Backpressure: each access holds cyc/stb until ack/err or watchdog expiry; start_i is ignored while busy or on done.
module sd_op_seq #(
    parameter int PROG_DEPTH = 32,
    parameter int POLL_LIMIT = 1024,
    parameter int WB_TIMEOUT = 4096,
    localparam int PC_W = $clog2(PROG_DEPTH)
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            start_i,
    input  logic [PC_W-1:0] start_pc_i,
    output logic [PC_W-1:0] op_addr_o,
    input  logic [42:0]     op_data_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [2:0]      err_o,
    output logic [31:0]     rd_dat_o,
    output logic [7:0]      sdc_wb_adr_o,
    output logic [31:0]     sdc_wb_dat_o,
    output logic [3:0]      sdc_wb_sel_o,
    output logic            sdc_wb_we_o,
    output logic            sdc_wb_cyc_o,
    output logic            sdc_wb_stb_o,
    input  logic [31:0]     sdc_wb_dat_i,
    input  logic            sdc_wb_ack_i,
    input  logic            sdc_wb_err_i
);
    localparam int PL_W = $clog2(POLL_LIMIT + 1);
    localparam int WD_W = $clog2(WB_TIMEOUT + 1);
    localparam logic [PC_W-1:0] LAST_PC   = PC_W'(PROG_DEPTH - 1);
    localparam logic [PL_W-1:0] POLL_LAST = PL_W'(POLL_LIMIT - 1);
    localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WB_TIMEOUT - 1);

    localparam logic [2:0] E_TIMEOUT = 3'd1;
    localparam logic [2:0] E_BUS     = 3'd2;
    localparam logic [2:0] E_POLL    = 3'd3;
    localparam logic [2:0] E_OVERRUN = 3'd4;
    localparam logic [2:0] E_FAIL    = 3'd5;

    typedef enum logic [2:0] {
        OP_HALT, OP_WRITE, OP_READ, OP_POLL_SET, OP_POLL_CLR, OP_WAIT, OP_JUMP, OP_FAIL
    } op_e;
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_BUS, ST_GAP, ST_DELAY} state_e;

    state_e          state_q, state_d;
    op_e             ir_op_q, ir_op_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [23:0]     cnt_q, cnt_d;
    logic [PL_W-1:0] poll_q, poll_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [7:0]      adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [2:0]      err_q, err_d;
    logic            done_q, done_d;
    logic [31:0]     rd_dat_q, rd_dat_d;

    op_e        f_op;
    logic       adv, fail, poll_met;
    logic [2:0] fail_code;

    assign f_op = op_e'(op_data_i[42:40]);
    // dat_q doubles as the poll mask while a POLL access is in flight
    assign poll_met = (ir_op_q == OP_POLL_SET) ? |(sdc_wb_dat_i & dat_q)
                                               : ~|(sdc_wb_dat_i & dat_q);

    always_comb begin
        state_d   = state_q;
        ir_op_d   = ir_op_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        wdog_d    = wdog_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        err_d     = err_q;
        done_d    = 1'b0;
        rd_dat_d  = rd_dat_q;
        adv       = 1'b0;
        fail      = 1'b0;
        fail_code = 3'd0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !done_q) begin
                    pc_d    = start_pc_i;
                    err_d   = 3'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_op_d = f_op;
                case (f_op)
                    OP_HALT: begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                    OP_JUMP: pc_d = op_data_i[PC_W-1:0];
                    OP_WAIT: begin
                        cnt_d   = op_data_i[23:0];
                        state_d = ST_DELAY;
                    end
                    OP_FAIL: begin
                        fail      = 1'b1;
                        fail_code = E_FAIL;
                    end
                    default: begin
                        state_d = ST_BUS;
                        poll_d  = '0;
                        wdog_d  = '0;
                        we_d    = (f_op == OP_WRITE);
                        adr_d   = op_data_i[39:32];
                        dat_d   = op_data_i[31:0];
                    end
                endcase
            end
            ST_BUS: begin
                if (sdc_wb_err_i) begin
                    fail      = 1'b1;
                    fail_code = E_BUS;
                end else if (sdc_wb_ack_i) begin
                    if (ir_op_q != OP_WRITE) rd_dat_d = sdc_wb_dat_i;
                    if (ir_op_q == OP_WRITE || ir_op_q == OP_READ || poll_met) begin
                        adv = 1'b1;
                    end else if (poll_q == POLL_LAST) begin
                        fail      = 1'b1;
                        fail_code = E_POLL;
                    end else begin
                        poll_d  = poll_q + 1'b1;
                        state_d = ST_GAP;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    fail      = 1'b1;
                    fail_code = E_TIMEOUT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_GAP: begin
                wdog_d  = '0;
                state_d = ST_BUS;
            end
            ST_DELAY: begin
                if (cnt_q == 24'd0) adv = 1'b1;
                else                cnt_d = cnt_q - 24'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // the program may not run off the end of the ROM
        if (adv) begin
            if (pc_q == LAST_PC) begin
                fail      = 1'b1;
                fail_code = E_OVERRUN;
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = ST_FETCH;
            end
        end
        if (fail) begin
            state_d = ST_IDLE;
            err_d   = fail_code;
            done_d  = 1'b1;
        end
        cyc_d = (state_d == ST_BUS);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= ST_IDLE;
            ir_op_q  <= OP_HALT;
            pc_q     <= '0;
            cnt_q    <= '0;
            poll_q   <= '0;
            wdog_q   <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_op_q  <= ir_op_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            poll_q   <= poll_d;
            wdog_q   <= wdog_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            err_q    <= err_d;
            done_q   <= done_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign op_addr_o    = pc_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign rd_dat_o     = rd_dat_q;
    assign sdc_wb_adr_o = adr_q;
    assign sdc_wb_dat_o = dat_q;
    assign sdc_wb_sel_o = 4'b1111;
    assign sdc_wb_we_o  = we_q;
    assign sdc_wb_cyc_o = cyc_q;
    assign sdc_wb_stb_o = cyc_q;
endmodule

// File: tb/tb_sd_op_seq.sv
// Directed bench for sd_op_seq: ROM programs, a latency-configurable Wishbone slave and an access scoreboard.
module tb_sd_op_seq;
    localparam int PD = 16;
    localparam int M_NORM = 0, M_NOACK = 1, M_ERR = 2;

    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
    } acc_t;

    logic        clk, rst_n, start;
    logic [3:0]  start_pc, op_addr;
    logic [42:0] op_data;
    logic        busy, done;
    logic [2:0]  err;
    logic [31:0] rd_dat, wb_dat_o, wb_dat_i;
    logic [7:0]  wb_adr;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;

    logic [42:0] rom [PD];
    acc_t        exp_q[$];
    logic [31:0] rd_q[$];
    int checks = 0, errors = 0;
    int mode = M_NORM, lat = 0, run = 0, last_run = 0;
    int busy_tot = 0, done_tot = 0, acc_tot = 0;
    int b_busy, b_done, b_acc;

    assign op_data = rom[op_addr];

    sd_op_seq #(.PROG_DEPTH(PD), .POLL_LIMIT(3), .WB_TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .start_pc_i(start_pc),
        .op_addr_o(op_addr), .op_data_i(op_data), .busy_o(busy), .done_o(done),
        .err_o(err), .rd_dat_o(rd_dat), .sdc_wb_adr_o(wb_adr), .sdc_wb_dat_o(wb_dat_o),
        .sdc_wb_sel_o(wb_sel), .sdc_wb_we_o(wb_we), .sdc_wb_cyc_o(wb_cyc),
        .sdc_wb_stb_o(wb_stb), .sdc_wb_dat_i(wb_dat_i), .sdc_wb_ack_i(wb_ack),
        .sdc_wb_err_i(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [42:0] enc(input logic [2:0] o, input logic [7:0] a, input logic [31:0] d);
        return {o, a, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: wait for negedge, tally outputs, act as the Wishbone slave and score accesses.
    task automatic tick();
        acc_t e;
        @(negedge clk);
        busy_tot += int'(busy);
        done_tot += int'(done);
        if (!rst_n) begin
            wb_ack = 1'b0; wb_err = 1'b0; run = 0;
        end else if (wb_cyc && wb_stb) begin
            run++;
            if (mode != M_NOACK && run > lat + 1) chk("stb_held_after_ack", run, lat + 1);
            if (mode != M_NOACK && run == lat + 1) begin
                wb_ack = 1'b1;
                wb_err = (mode == M_ERR);
                if (!wb_we) wb_dat_i = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                acc_tot++;
                chk("acc_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("acc_we", wb_we, e.we);
                    chk("acc_adr", wb_adr, e.adr);
                    if (e.we) chk("acc_wdat", wb_dat_o, e.dat);
                end
            end else begin
                wb_ack = 1'b0; wb_err = 1'b0;
            end
        end else begin
            wb_ack = 1'b0; wb_err = 1'b0;
            if (run != 0) last_run = run;
            run = 0;
        end
    endtask

    task automatic run_prog(input logic [3:0] pc, input int budget);
        bit got = 0;
        b_busy = busy_tot; b_done = done_tot; b_acc = acc_tot;
        start = 1'b1; start_pc = pc;
        tick();
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin got = 1; break; end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic finish_prog(input string tag, input int exp_err, input int exp_busy, input int exp_acc);
        tick(); tick();
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_cycles"}, busy_tot - b_busy, exp_busy);
        chk({tag, "_done_pulses"}, done_tot - b_done, 1);
        chk({tag, "_accesses"}, acc_tot - b_acc, exp_acc);
        chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; start_pc = '0;
        wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
        for (int i = 0; i < PD; i++) rom[i] = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_err", err, 0);        chk("rst_rd_dat", rd_dat, 0);
        chk("rst_cyc", wb_cyc, 0);     chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);       chk("rst_adr", wb_adr, 0);
        chk("rst_dat", wb_dat_o, 0);   chk("rst_pc", op_addr, 0);
        chk("sel_const", wb_sel, 4'hF);
        rst_n = 1'b1;
        tick();

        // write then read, ack one cycle late
        rom[0] = enc(3'd1, 8'h24, 32'h4);
        rom[1] = enc(3'd2, 8'h24, 32'h0);
        rom[2] = enc(3'd0, 8'h00, 32'h0);
        lat = 1; mode = M_NORM;
        exp_q.push_back('{1'b1, 8'h24, 32'h4});
        exp_q.push_back('{1'b0, 8'h24, 32'h0});
        rd_q.push_back(32'h4);
        run_prog(4'd0, 40);
        finish_prog("wr_rd_lat1", 0, 7, 2);
        chk("wr_rd_lat1_rd_dat", rd_dat, 32'h4);

        // same program, ack on first stb cycle
        lat = 0;
        exp_q.push_back('{1'b1, 8'h24, 32'h4});
        exp_q.push_back('{1'b0, 8'h24, 32'h0});
        rd_q.push_back(32'hA5A5_0001);
        run_prog(4'd0, 40);
        finish_prog("wr_rd_lat0", 0, 5, 2);
        chk("wr_rd_lat0_stb_len", last_run, 1);
        chk("wr_rd_lat0_rd_dat", rd_dat, 32'hA5A5_0001);

        // POLL_SET: 0,0,1 with one-cycle gaps between reads
        rom[0] = enc(3'd3, 8'h34, 32'h1);
        rom[1] = enc(3'd0, 8'h00, 32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 8'h34, 32'h0});
        rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
        run_prog(4'd0, 40);
        finish_prog("poll_set", 0, 7, 3);
        chk("poll_set_rd_dat", rd_dat, 32'h1);
        chk("poll_set_pc", op_addr, 1);

        // POLL_CLR: bit set once, then clear
        rom[0] = enc(3'd4, 8'h34, 32'h1);
        for (int i = 0; i < 2; i++) exp_q.push_back('{1'b0, 8'h34, 32'h0});
        rd_q.push_back(32'hFF); rd_q.push_back(32'hFE);
        run_prog(4'd0, 40);
        finish_prog("poll_clr", 0, 5, 2);
        chk("poll_clr_rd_dat", rd_dat, 32'hFE);

        // poll limit (3) exhausted
        rom[0] = enc(3'd3, 8'h34, 32'h1);
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 8'h34, 32'h0});
        rd_q.push_back(32'h2); rd_q.push_back(32'h4); rd_q.push_back(32'h8); rd_q.push_back(32'h1);
        run_prog(4'd0, 40);
        finish_prog("poll_limit", 3, 6, 3);
        chk("poll_limit_rd_dat", rd_dat, 32'h8);
        rd_q.delete();

        // watchdog: ack never comes
        rom[0] = enc(3'd1, 8'h10, 32'hAA);
        mode = M_NOACK;
        run_prog(4'd0, 60);
        finish_prog("timeout", 1, 17, 0);
        chk("timeout_stb_len", last_run, 16);

        // err and ack together on a read: rd_dat keeps its old value
        mode = M_ERR;
        rom[0] = enc(3'd2, 8'h08, 32'h0);
        exp_q.push_back('{1'b0, 8'h08, 32'h0});
        rd_q.push_back(32'h1234);
        run_prog(4'd0, 40);
        finish_prog("bus_err", 2, 2, 1);
        chk("bus_err_rd_dat", rd_dat, 32'h8);
        mode = M_NORM;
        rd_q.delete();

        // JUMP over FAIL into WAIT 5 then HALT; a start in the done cycle is ignored
        rom[0] = enc(3'd6, 8'h00, 32'h3);
        rom[1] = enc(3'd7, 8'h00, 32'h0);
        rom[2] = enc(3'd0, 8'h00, 32'h0);
        rom[3] = enc(3'd5, 8'h00, 32'h5);
        rom[4] = enc(3'd0, 8'h00, 32'h0);
        run_prog(4'd0, 40);
        start = 1'b1; start_pc = 4'd1;
        tick();
        start = 1'b0;
        chk("start_on_done_busy", busy, 0);
        finish_prog("jump_wait", 0, 9, 0);
        chk("jump_wait_pc", op_addr, 4);

        // FAIL opcode
        run_prog(4'd1, 20);
        finish_prog("fail_op", 5, 1, 0);

        // WRITE in the last ROM word overruns the program
        rom[PD-1] = enc(3'd1, 8'h20, 32'h1);
        exp_q.push_back('{1'b1, 8'h20, 32'h1});
        run_prog(4'(PD - 1), 20);
        finish_prog("overrun", 4, 2, 1);

        // reset in the middle of a poll access
        rom[0] = enc(3'd3, 8'h34, 32'h1);
        rom[1] = enc(3'd0, 8'h00, 32'h0);
        lat = 3;
        start = 1'b1; start_pc = 4'd0;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wb_cyc) begin seen = 1; break; end
        end
        chk("rst_mid_cyc_seen", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", wb_cyc, 0);
        chk("rst_mid_stb", wb_stb, 0);
        chk("rst_mid_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // normal run after the reset
        rom[0] = enc(3'd1, 8'h24, 32'h4);
        rom[1] = enc(3'd2, 8'h24, 32'h0);
        rom[2] = enc(3'd0, 8'h00, 32'h0);
        lat = 1;
        exp_q.push_back('{1'b1, 8'h24, 32'h4});
        exp_q.push_back('{1'b0, 8'h24, 32'h0});
        rd_q.push_back(32'h4);
        run_prog(4'd0, 40);
        finish_prog("after_rst", 0, 7, 2);
        chk("after_rst_rd_dat", rd_dat, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_op_seq.md
# sd_op_seq

Parametrised, program-driven Wishbone master that sequences SD-controller register accesses: writes, reads, bit-polls, timed waits and jumps, with per-access timeout and poll-retry limits. It sits between a host-side program ROM and the SD controller's 8-bit-addressed, 32-bit Wishbone slave port. It is the general successor to the fixed init sequencer: the program lives in an external ROM of any depth, can start at any entry point, and can report failures.

## Interface
- PROG_DEPTH, 32: program words; PC_W = $clog2(PROG_DEPTH)
- POLL_LIMIT, 1024: max reads per POLL op before failure (≥1)
- WB_TIMEOUT, 4096: max cycles an access may wait for ack (≥1)
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset; asynchronous, active-low
- start_i  in  1  one-cycle pulse; run program from start_pc_i (ignored while busy_o)
- start_pc_i  in  PC_W  entry point
- op_addr_o  out  PC_W  ROM address (= pc)
- op_data_i  in  43  ROM word {op[2:0], adr[7:0], dat[31:0]}, combinational ROM
- busy_o  out  1  program running
- done_o  out  1  one-cycle pulse on HALT or error
- err_o  out  3  error code, held until next accepted start
- rd_dat_o  out  32  data of last READ/POLL access
- sdc_wb_adr_o  out  8, sdc_wb_dat_o  out  32, sdc_wb_sel_o  out  4 (constant 4'b1111), sdc_wb_we_o  out  1, sdc_wb_cyc_o  out  1, sdc_wb_stb_o  out  1
- sdc_wb_dat_i  in  32, sdc_wb_ack_i  in  1, sdc_wb_err_i  in  1

## Operation
- Opcodes: 0 HALT; 1 WRITE adr←dat; 2 READ adr; 3 POLL_SET (read adr until (rdata & dat)≠0); 4 POLL_CLR (until (rdata & dat)=0); 5 WAIT dat[23:0] extra cycles; 6 JUMP to dat[PC_W-1:0]; 7 FAIL.
- Error codes: 0 none, 1 timeout, 2 bus error, 3 poll limit, 4 pc overrun, 5 FAIL opcode.
- States: IDLE, FETCH, BUS, GAP, DELAY.
- IDLE: start_i → pc←start_pc_i, err_o←0, busy_o←1, FETCH.
- FETCH (1 cycle): decode op_data_i, latch into IR. HALT → IDLE, done_o. JUMP → pc←target, FETCH. WAIT → cnt←dat[23:0], DELAY. FAIL → error 5. WRITE/READ/POLL → BUS, poll_cnt←0, wdog←0.
- BUS: cyc/stb/we/adr/dat registered, held constant until ack, err or timeout.
  - err_i (priority over ack) → error 2. ack → rd_dat_o←dat_i (reads only); WRITE/READ → advance; POLL met → advance; POLL not met: poll_cnt = POLL_LIMIT-1 → error 3, else poll_cnt+1, GAP.
  - wdog reaches WB_TIMEOUT-1 without ack/err → error 1.
- GAP: one idle-bus cycle, wdog←0, back to BUS.
- DELAY: cnt=0 → advance, else cnt-1.
- Advance: pc = PROG_DEPTH-1 → error 4; else pc+1, FETCH. No wrap-around.
- Error: cyc/stb drop, err_o←code, done_o pulse, busy_o←0, IDLE.
- start_i during busy_o ignored; start_i same cycle as done_o ignored.

## Timing
- Reset (async, immediate): state IDLE, pc 0, busy_o 0, done_o 0, err_o 0, rd_dat_o 0, cyc/stb/we 0, adr/dat 0. Reset mid-access drops cyc/stb without waiting for ack.
- start_i at edge N → busy_o and FETCH from N+1; cyc/stb high from N+2 for bus ops.
- Access with ack on first stb cycle: cyc/stb high exactly 1 cycle; next FETCH the following cycle. Bus op cost = 1 + (ack latency+1) cycles.
- ack sampled only while stb high; cyc/stb low the cycle after ack.
- POLL retry cost = access + 1 GAP cycle; cyc low during GAP (back-to-back accesses never merge).
- WAIT n: 1 FETCH + n+1 DELAY cycles.
- JUMP/HALT: 1 cycle each. done_o asserted the cycle after HALT fetch / error detection, with busy_o falling the same cycle.
- Timeout: cyc/stb high for exactly WB_TIMEOUT cycles, then low.

## Test plan
- Program {WRITE 0x24←4, READ 0x24, HALT}, slave ack 1 cycle later, returns 0x4 → one write then one read on bus, rd_dat_o=0x4, done_o 1 pulse, err_o=0, busy total 7 cycles.
- POLL_SET 0x34 mask 0x1, slave returns 0,0,1 → 3 reads separated by 1-cycle gaps, pc advances, err_o=0; with POLL_LIMIT=2 same stimulus → err_o=3 after 2 reads.
- WRITE with ack never asserted, WB_TIMEOUT=16 → stb high exactly 16 cycles, err_o=1, done_o pulse.
- sdc_wb_err_i and ack together on READ → err_o=2, rd_dat_o unchanged.
- {JUMP 3, FAIL, –, WAIT 5, HALT} from start_pc 0 → FAIL skipped, 6 DELAY cycles, HALT; program ending at PROG_DEPTH-1 with WRITE → err_o=4.
- Assert reset mid-poll with cyc high → cyc/stb/busy_o 0 immediately; new start_i after release runs normally.
